// File: rtl/sa_pkg.sv
// Shared constants and types for the systolic-array row collector.
package sa_pkg;

    // Width of one tagged column word: payload plus the valid tag.
    function automatic int unsigned tag_width(int unsigned w_data);
        return w_data + 1;
    endfunction

    // Bit index of the valid tag within a tagged column word.
    function automatic int unsigned valid_bit(int unsigned w_data);
        return w_data;
    endfunction

    // Output row register state.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sa_col_fifo.sv
// Per-column FIFO that buffers one systolic-array column's words until a full row exists.
module sa_col_fifo #(
    parameter int unsigned W_DATA = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W_DATA-1:0]        i_data,
    output logic [W_DATA-1:0]        o_data_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [W_DATA-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign push_ok = i_push & (~o_full_c | pop_ok);
    assign pop_ok  = i_pop & ~o_empty_c;

    // Next-state for storage, power-of-two pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_data_c  = mem_q[rd_ptr_q];
    assign o_full_c  = (count_q == CW'(DEPTH));
    assign o_empty_c = (count_q == '0);
    assign o_count   = count_q;

endmodule

// File: rtl/sa_row_collector.sv
// Collects skewed per-column words from a systolic array and emits aligned rows.
module sa_row_collector
    import sa_pkg::*;
#(
    parameter int unsigned COL    = 3,
    parameter int unsigned W_DATA = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [(W_DATA+1)*COL-1:0]  i_data,
    output logic [W_DATA*COL-1:0]      o_row,
    output logic                       o_row_valid,
    input  logic                       i_row_ready,
    output logic [COL-1:0]             o_overflow,
    output logic                       o_busy
);

    localparam int unsigned W_TAG = tag_width(W_DATA);
    localparam int unsigned VBIT  = valid_bit(W_DATA);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    out_state_e                    state_q, state_d;
    logic [W_DATA*COL-1:0]         row_q, row_d, row_next;
    logic [COL-1:0]                ovf_q, ovf_d;
    logic                          busy_q, busy_d;

    logic [COL-1:0]                col_vld;
    logic [COL-1:0]                push;
    logic [COL-1:0]                full;
    logic [COL-1:0]                empty;
    logic [COL-1:0]                ovf_set;
    logic [COL-1:0]                nonempty_nxt;
    logic [COL-1:0][W_DATA-1:0]    col_payload;
    logic [COL-1:0][W_DATA-1:0]    head;
    logic [COL-1:0][CW-1:0]        count;
    logic [COL-1:0][CW-1:0]        count_nxt;
    logic                          pop_c;

    // Pop a row when every column has a head word and the output slot is free or draining.
    assign pop_c = (&(~empty)) & ((state_q == ST_EMPTY) | i_row_ready);

    // Per-column unpacking, push/drop decision and buffering.
    for (genvar c = 0; c < int'(COL); c++) begin : g_col
        localparam int unsigned TAG_LSB = W_TAG * (COL - 1 - c);
        localparam int unsigned ROW_LSB = W_DATA * (COL - 1 - c);

        assign col_vld[c]     = i_data[TAG_LSB + VBIT];
        assign col_payload[c] = i_data[TAG_LSB +: W_DATA];
        assign push[c]        = col_vld[c] & (~full[c] | pop_c);
        assign ovf_set[c]     = col_vld[c] & full[c] & ~pop_c;
        assign count_nxt[c]   = count[c] + CW'(push[c]) - CW'(pop_c);
        assign nonempty_nxt[c] = (count_nxt[c] != '0);
        assign row_next[ROW_LSB +: W_DATA] = head[c];

        sa_col_fifo #(
            .W_DATA (W_DATA),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (i_clk),
            .rst_n     (i_rst_n),
            .i_push    (push[c]),
            .i_pop     (pop_c),
            .i_data    (col_payload[c]),
            .o_data_c  (head[c]),
            .o_full_c  (full[c]),
            .o_empty_c (empty[c]),
            .o_count   (count[c])
        );
    end

    // Output-state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-state transitions: fill on pop, drain on accept without a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (pop_c)            state_d = ST_FULL;
            ST_FULL:  if (pop_c)            state_d = ST_FULL;
                      else if (i_row_ready) state_d = ST_EMPTY;
            default:                        state_d = ST_EMPTY;
        endcase
    end

    // Next values for row data, sticky overflow and busy.
    always_comb begin
        row_d  = row_q;
        ovf_d  = ovf_q | ovf_set;
        busy_d = (state_d == ST_FULL) | (|nonempty_nxt);
        if (pop_c) begin
            row_d = row_next;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q  <= '0;
            ovf_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
        end
    end

    assign o_row       = row_q;
    assign o_row_valid = (state_q == ST_FULL);
    assign o_overflow  = ovf_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_sa_row_collector.sv
// Directed self-checking bench for sa_row_collector (COL=3, W_DATA=8, DEPTH=4).
module tb_sa_row_collector;

    logic        clk;
    logic        rst_n;
    logic [26:0] din;
    logic [23:0] row;
    logic        row_valid;
    logic        row_ready;
    logic [2:0]  ovf;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    sa_row_collector #(
        .COL    (3),
        .W_DATA (8),
        .DEPTH  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (din),
        .o_row       (row),
        .o_row_valid (row_valid),
        .i_row_ready (row_ready),
        .o_overflow  (ovf),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] din;
        logic        rdy;
        logic [23:0] row;
        logic        vld;
        logic [2:0]  ovf;
        logic        busy;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [26:0] mk(input logic v0, input logic [7:0] d0,
                                       input logic v1, input logic [7:0] d1,
                                       input logic v2, input logic [7:0] d2);
        return {v0, d0, v1, d1, v2, d2};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [23:0] e_row, input logic e_vld,
                             input logic [2:0] e_ovf, input logic e_busy);
        check({name, ".row"},  32'(row),       32'(e_row));
        check({name, ".vld"},  32'(row_valid), 32'(e_vld));
        check({name, ".ovf"},  32'(ovf),       32'(e_ovf));
        check({name, ".busy"}, 32'(busy),      32'(e_busy));
    endtask

    // Drive inputs away from the edge, clock once, sample 1 ns after the edge.
    task automatic step(input logic [26:0] d, input logic rdy);
        din       = d;
        row_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    logic [26:0] idle;
    logic [23:0] e_row;

    initial begin
        idle      = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        din       = idle;
        row_ready = 1'b0;
        rst_n     = 1'b0;

        // Skewed wavefront, then ignored invalid-tag words.
        tbl[0] = '{mk(1,8'h11,0,8'h00,0,8'h00), 1'b1, 24'h000000, 1'b0, 3'b000, 1'b1};
        tbl[1] = '{mk(0,8'h00,1,8'h22,0,8'h00), 1'b1, 24'h000000, 1'b0, 3'b000, 1'b1};
        tbl[2] = '{mk(0,8'h00,0,8'h00,1,8'h33), 1'b1, 24'h000000, 1'b0, 3'b000, 1'b1};
        tbl[3] = '{idle,                        1'b1, 24'h112233, 1'b1, 3'b000, 1'b1};
        tbl[4] = '{idle,                        1'b1, 24'h112233, 1'b0, 3'b000, 1'b0};
        tbl[5] = '{mk(0,8'hFF,0,8'hFF,0,8'hFF), 1'b1, 24'h112233, 1'b0, 3'b000, 1'b0};
        tbl[6] = '{mk(0,8'hFF,0,8'hFF,0,8'hFF), 1'b0, 24'h112233, 1'b0, 3'b000, 1'b0};

        #8;
        check_out("reset", 24'h0, 1'b0, 3'b000, 1'b0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].din, tbl[i].rdy);
            check_out($sformatf("tbl%0d", i), tbl[i].row, tbl[i].vld, tbl[i].ovf, tbl[i].busy);
        end

        // Invalid tags for 10 cycles: nothing is buffered.
        for (int i = 0; i < 10; i++) begin
            step(mk(0, 8'hFF, 0, 8'hFF, 0, 8'hFF), 1'b1);
            check($sformatf("inv%0d.vld", i),  32'(row_valid), 32'(0));
            check($sformatf("inv%0d.busy", i), 32'(busy),      32'(0));
        end

        // Backpressure: three rows streamed with ready low, first one held.
        step(mk(1, 8'h01, 1, 8'h02, 1, 8'h03), 1'b0);
        check_out("bp0", 24'h112233, 1'b0, 3'b000, 1'b1);
        step(mk(1, 8'h04, 1, 8'h05, 1, 8'h06), 1'b0);
        check_out("bp1", 24'h010203, 1'b1, 3'b000, 1'b1);
        step(mk(1, 8'h07, 1, 8'h08, 1, 8'h09), 1'b0);
        check_out("bp2", 24'h010203, 1'b1, 3'b000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(idle, 1'b0);
            check_out($sformatf("bp_hold%0d", i), 24'h010203, 1'b1, 3'b000, 1'b1);
        end
        step(idle, 1'b1);
        check_out("bp_rel0", 24'h040506, 1'b1, 3'b000, 1'b1);
        step(idle, 1'b1);
        check_out("bp_rel1", 24'h070809, 1'b1, 3'b000, 1'b1);
        step(idle, 1'b1);
        check_out("bp_rel2", 24'h070809, 1'b0, 3'b000, 1'b0);

        // Overflow: col1 sends DEPTH+2 words alone with ready low.
        for (int i = 0; i < 6; i++) begin
            step(mk(0, 8'h00, 1, 8'(8'hA0 + i), 0, 8'h00), 1'b0);
            check_out($sformatf("ovf_c1_%0d", i), 24'h070809, 1'b0,
                      (i >= 4) ? 3'b010 : 3'b000, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 8'(8'hB0 + i), 0, 8'h00, 1, 8'(8'hC0 + i)), 1'b0);
            if (i == 0) check_out("ovf_fill0", 24'h070809, 1'b0, 3'b010, 1'b1);
            else        check_out($sformatf("ovf_fill%0d", i), 24'hB0A0C0, 1'b1, 3'b010, 1'b1);
        end
        step(idle, 1'b0);
        check_out("ovf_hold", 24'hB0A0C0, 1'b1, 3'b010, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step(idle, 1'b1);
            e_row = {8'(8'hB0 + i), 8'(8'hA0 + i), 8'(8'hC0 + i)};
            check_out($sformatf("ovf_drain%0d", i), e_row, 1'b1, 3'b010, 1'b1);
        end
        step(idle, 1'b1);
        check_out("ovf_done", 24'hB3A3C3, 1'b0, 3'b010, 1'b0);

        // Reset mid-operation with two columns partially filled.
        step(mk(1, 8'h55, 1, 8'h66, 0, 8'h00), 1'b0);
        step(mk(1, 8'h56, 1, 8'h67, 0, 8'h00), 1'b0);
        check_out("pre_rst", 24'hB3A3C3, 1'b0, 3'b010, 1'b1);
        din   = mk(1, 8'h77, 1, 8'h77, 1, 8'h77);
        rst_n = 1'b0;
        #2;
        check_out("rst_async", 24'h0, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_edge", 24'h0, 1'b0, 3'b000, 1'b0);
        rst_n = 1'b1;
        step(mk(1, 8'h0A, 1, 8'h0B, 1, 8'h0C), 1'b1);
        check_out("post_rst0", 24'h0, 1'b0, 3'b000, 1'b1);
        step(idle, 1'b1);
        check_out("post_rst1", 24'h0A0B0C, 1'b1, 3'b000, 1'b1);
        step(idle, 1'b1);
        check_out("post_rst2", 24'h0A0B0C, 1'b0, 3'b000, 1'b0);

        // Full rate: 16 rows back to back with ready high.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) step(mk(1, 8'(i), 1, 8'(8'h40 + i), 1, 8'(8'h80 + i)), 1'b1);
            else        step(idle, 1'b1);
            if (i >= 1 && i <= 16) begin
                e_row = {8'(i - 1), 8'(8'h40 + i - 1), 8'(8'h80 + i - 1)};
                check($sformatf("fr%0d.vld", i), 32'(row_valid), 32'(1));
                check($sformatf("fr%0d.row", i), 32'(row),       32'(e_row));
            end else begin
                check($sformatf("fr%0d.vld", i), 32'(row_valid), 32'(0));
            end
        end
        check("fr_end.busy", 32'(busy), 32'(0));
        check("fr_end.ovf",  32'(ovf),  32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sa_row_collector.md
SA_ROW_COLLECTOR -- requirements
Module: sa_row_collector

Interface
REQ-001 SHALL have parameter COL, default 3, number of systolic-array columns.
REQ-002 SHALL have parameter W_DATA, default 8, payload bits per column.
REQ-003 SHALL have parameter DEPTH, default 4, per-column FIFO entries (power of 2, >=2).
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_data  input  (W_DATA+1)*COL  tagged column words; column c occupies slice [(W_DATA+1)*(COL-c)-1 -: W_DATA+1]; bit W_DATA of each slice is the valid tag, bits W_DATA-1:0 are payload.
REQ-007 SHALL have port o_row  output  W_DATA*COL  aligned row; column c occupies slice [W_DATA*(COL-c)-1 -: W_DATA].
REQ-008 SHALL have port o_row_valid  output  1  o_row holds a complete row.
REQ-009 SHALL have port i_row_ready  input  1  downstream accepts o_row this cycle.
REQ-010 SHALL have port o_overflow  output  COL  sticky per-column word-dropped flag.
REQ-011 SHALL have port o_busy  output  1  any FIFO non-empty or o_row_valid high.

Function
REQ-012 Column c SHALL push its payload into FIFO c on a rising edge whenever its valid tag is 1 and the FIFO is not full or is popped in the same cycle.
REQ-013 A tagged word arriving at a full FIFO not popped that cycle SHALL be dropped, FIFO contents SHALL be unchanged and o_overflow[c] SHALL set.
REQ-014 Words with valid tag 0 SHALL be ignored regardless of payload.
REQ-015 A row pop SHALL remove the head of all COL FIFOs simultaneously, only when every FIFO is non-empty and the output register is EMPTY or being accepted (o_row_valid & i_row_ready).
REQ-016 Output register SHALL be a 2-state machine: EMPTY (o_row_valid=0) and FULL (o_row_valid=1); EMPTY->FULL on pop; FULL->EMPTY on accept with no pop; FULL->FULL with new data on accept plus pop; FULL holds o_row stable while i_row_ready=0.
REQ-017 Latency: when the last column's word is written at edge k and the output register is EMPTY, o_row_valid SHALL be 1 after edge k+1.
REQ-018 Throughput SHALL be one row per cycle with i_row_ready held high and all columns supplying one word per cycle.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH with distinct full and empty.
REQ-020 Row content SHALL be the k-th accepted word of each column, independent of per-column arrival skew up to DEPTH words.
REQ-021 o_overflow bits SHALL clear only on reset.

Reset
REQ-022 On i_rst_n=0, all FIFOs SHALL empty, state SHALL go EMPTY, o_row_valid=0, o_row=0, o_overflow=0, o_busy=0, asynchronously.
REQ-023 Reset asserted mid-operation SHALL discard all buffered words and any pending row; first push after deassertion SHALL be treated as word 0.
REQ-024 No push or pop SHALL occur on the edge on which i_rst_n is low.

Structure
REQ-025 Package sa_pkg SHALL hold tag width constant (W_DATA+1), valid-tag bit index, and output-state enum.
REQ-026 Per-column buffering SHALL be sub-module sa_col_fifo (push, pop, data, full, empty, count), instantiated COL times in a generate loop.

Verification
REQ-027 Skewed wavefront: col0=0x11 at cycle 0, col1=0x22 at cycle 1, col2=0x33 at cycle 2, ready=1 -> o_row=0x112233 with o_row_valid high for exactly one cycle after edge 3.
REQ-028 Backpressure: ready=0, 3 rows streamed -> first row held stable, FIFOs fill; ready=1 -> rows emitted in order on consecutive cycles, o_overflow=0.
REQ-029 Overflow: ready=0, col1 sends DEPTH+2 words while others send none -> o_overflow=3'b010, first DEPTH col1 words retained and later emitted in order.
REQ-030 Invalid tags: payload 0xFF with tag 0 on all columns for 10 cycles -> no pushes, o_busy=0, o_row_valid=0.
REQ-031 Reset mid-operation: 2 columns partially filled, i_rst_n pulsed low -> all outputs zero immediately; new full row after release emitted with new data only.
REQ-032 Full-rate: 16 rows, one word per column per cycle, ready=1 -> 16 consecutive o_row_valid cycles, data matches the sent sequence.
